rs_encoder: RTL and testbench

RS_ENCODER -- requirements
Module: rs_encoder

---
 rtl/rs_encoder.sv | 134 +++++++++++++
 tb/tb_rs_encoder.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rs_encoder.sv
// rtl/rs_encoder.sv - systematic RS(255,239) encoder over GF(2^8), LFSR based, one symbol per cycle
module rs_encoder #(
    parameter int n = 255,
    parameter int k = 239,
    parameter int t = 8,
    parameter int m = 8
) (
    input  logic         clk_in,
    input  logic         sys_rst_n,
    input  logic         sync,
    input  logic [m-1:0] data_in,
    output logic         in_ready,
    output logic [m-1:0] data_out,
    output logic         out_valid,
    output logic         out_sync
);

    localparam int NP = 2 * t;
    localparam logic [m-1:0] PRIM = m'('h1D);

    typedef enum logic [1:0] {IDLE, MSG, PARITY} state_t;

    function automatic logic [m-1:0] gf_mul(input logic [m-1:0] a, input logic [m-1:0] b);
        logic [m-1:0] acc;
        logic [m-1:0] x;
        acc = '0;
        x   = a;
        for (int i = 0; i < m; i++) begin
            if (b[i]) acc ^= x;
            x = {x[m-2:0], 1'b0} ^ (x[m-1] ? PRIM : '0);
        end
        return acc;
    endfunction

    // Generator coefficients g0..g(NP-1), packed low degree first; g(NP) = 1 is implicit.
    function automatic logic [NP*m-1:0] gen_poly();
        logic [m-1:0]    p [NP+1];
        logic [m-1:0]    root;
        logic [NP*m-1:0] packed_g;
        root = m'(1);
        for (int j = 0; j <= NP; j++) p[j] = '0;
        p[0] = m'(1);
        for (int i = 0; i < NP; i++) begin
            for (int j = NP; j > 0; j--) p[j] = p[j-1] ^ gf_mul(p[j], root);
            p[0] = gf_mul(p[0], root);
            root = gf_mul(root, m'(2));
        end
        packed_g = '0;
        for (int j = 0; j < NP; j++) packed_g[j*m +: m] = p[j];
        return packed_g;
    endfunction

    localparam logic [NP*m-1:0] G = gen_poly();

    state_t       state;
    logic [7:0]   cnt;
    logic         rst_ok;
    logic [m-1:0] r    [NP];
    logic [m-1:0] prod [NP];
    logic [m-1:0] fb;
    logic         accept;

    // Ready only in IDLE; IDLE coincides with the cycle the last parity symbol is on data_out,
    // so a sync there streams codewords back to back every n cycles.
    assign in_ready = rst_ok && (state == IDLE);
    assign accept   = in_ready && !sync;

    always_comb begin
        fb = '0;
        if (accept)
            fb = data_in;
        else if (state == MSG)
            fb = data_in ^ r[NP-1];
        for (int i = 0; i < NP; i++)
            prod[i] = gf_mul(fb, G[i*m +: m]);
    end

    always_ff @(posedge clk_in or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            rst_ok    <= 1'b0;
            data_out  <= '0;
            out_valid <= 1'b0;
            out_sync  <= 1'b1;
            for (int i = 0; i < NP; i++) r[i] <= '0;
        end else begin
            rst_ok    <= 1'b1;
            data_out  <= '0;
            out_valid <= 1'b0;
            out_sync  <= 1'b1;
            case (state)
                IDLE: begin
                    if (accept) begin
                        state     <= MSG;
                        cnt       <= 8'd1;
                        data_out  <= data_in;
                        out_valid <= 1'b1;
                        out_sync  <= 1'b0;
                    end
                end
                MSG: begin
                    data_out  <= data_in;
                    out_valid <= 1'b1;
                    if (cnt == 8'(k - 1)) begin
                        state <= PARITY;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                PARITY: begin
                    data_out  <= r[NP-1];
                    out_valid <= 1'b1;
                    if (cnt == 8'(n - k - 1)) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
            // On acceptance the previous register contents are treated as zero (fresh frame).
            if (accept) begin
                for (int i = 0; i < NP; i++) r[i] <= prod[i];
            end else if (state != IDLE) begin
                r[0] <= prod[0];
                for (int i = 1; i < NP; i++) r[i] <= r[i-1] ^ prod[i];
            end
        end
    end

endmodule

// File: tb/tb_rs_encoder.sv
// tb/tb_rs_encoder.sv - randomized self-checking bench for rs_encoder against a polynomial-division model
module tb_rs_encoder;

    localparam int N  = 255;
    localparam int K  = 239;
    localparam int NP = 16;

    typedef logic [7:0] msg_t [K];
    typedef logic [7:0] cw_t  [N];

    logic       clk_in    = 1'b0;
    logic       sys_rst_n = 1'b0;
    logic       sync      = 1'b1;
    logic [7:0] data_in   = 8'h00;
    logic       in_ready;
    logic [7:0] data_out;
    logic       out_valid;
    logic       out_sync;

    rs_encoder #(.n(N), .k(K), .t(8), .m(8)) dut (
        .clk_in    (clk_in),
        .sys_rst_n (sys_rst_n),
        .sync      (sync),
        .data_in   (data_in),
        .in_ready  (in_ready),
        .data_out  (data_out),
        .out_valid (out_valid),
        .out_sync  (out_sync)
    );

    always #5 clk_in = ~clk_in;

    int         checks     = 0;
    int         failures   = 0;
    int         cyc        = 0;
    int         next_ready = 1 << 30;
    int         cw_count   = 0;
    int         cap_n      = -1;
    logic [7:0] gexp [256];
    int         glog [256];
    logic [7:0] gpoly [17];
    logic [7:0] exp_data [int];
    bit         exp_first [int];
    cw_t        cap;
    cw_t        last_cw;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, req);
        end
    endtask

    function automatic logic [7:0] mul(input logic [7:0] a, input logic [7:0] b);
        if (a == 8'h00 || b == 8'h00) return 8'h00;
        return gexp[(glog[a] + glog[b]) % 255];
    endfunction

    task automatic build_tables();
        logic [8:0] x;
        x = 9'h001;
        for (int i = 0; i < 255; i++) begin
            gexp[i] = x[7:0];
            glog[x[7:0]] = i;
            x = x << 1;
            if (x[8]) x = x ^ 9'h11D;
        end
        gexp[255] = gexp[0];
        glog[0] = 0;
    endtask

    // Product of (x + alpha^i) for i = 0..nr-1, coefficient index = degree.
    task automatic build_gen(input int nr);
        for (int j = 0; j <= NP; j++) gpoly[j] = 8'h00;
        gpoly[0] = 8'h01;
        for (int i = 0; i < nr; i++) begin
            for (int j = NP; j > 0; j--) gpoly[j] = gpoly[j-1] ^ mul(gpoly[j], gexp[i]);
            gpoly[0] = mul(gpoly[0], gexp[i]);
        end
    endtask

    // Codeword = message followed by (M(x) * x^16 mod g(x)), highest degree first.
    task automatic encode(input msg_t msg, output cw_t cw);
        logic [7:0] poly [N];
        logic [7:0] c;
        for (int d = 0; d < N; d++) poly[d] = 8'h00;
        for (int j = 0; j < K; j++) poly[N-1-j] = msg[j];
        for (int d = N - 1; d >= NP; d--) begin
            c = poly[d];
            if (c != 8'h00)
                for (int i = 0; i <= NP; i++) poly[d-NP+i] ^= mul(c, gpoly[i]);
        end
        for (int j = 0; j < K; j++) cw[j] = msg[j];
        for (int i = 0; i < NP; i++) cw[K+i] = poly[NP-1-i];
    endtask

    function automatic logic [7:0] syndrome(input cw_t c, input int i);
        logic [7:0] acc;
        acc = 8'h00;
        for (int j = 0; j < N; j++) acc = mul(acc, gexp[i]) ^ c[j];
        return acc;
    endfunction

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    initial forever begin
        @(posedge clk_in);
        cyc++;
    end

    initial forever begin
        @(negedge clk_in);
        if (!sys_rst_n) begin
            chk("rst_in_ready", in_ready, 0);
            chk("rst_out_valid", out_valid, 0);
            chk("rst_out_sync", out_sync, 1);
            chk("rst_data_out", data_out, 0);
            cap_n = -1;
        end else begin
            chk("in_ready", in_ready, cyc >= next_ready);
            if (exp_data.exists(cyc)) begin
                chk("out_valid", out_valid, 1);
                chk("data_out", data_out, exp_data[cyc]);
                chk("out_sync", out_sync, exp_first.exists(cyc) ? 0 : 1);
            end else begin
                chk("idle_out_valid", out_valid, 0);
                chk("idle_data_out", data_out, 0);
                chk("idle_out_sync", out_sync, 1);
            end
            if (out_valid === 1'b1) begin
                if (out_sync === 1'b0) cap_n = 0;
                if (cap_n >= 0) begin
                    cap[cap_n] = data_out;
                    cap_n++;
                    if (cap_n == N) begin
                        int nz;
                        nz = 0;
                        for (int i = 0; i < NP; i++) if (syndrome(cap, i) != 8'h00) nz++;
                        chk("syndromes_nonzero", nz, 0);
                        last_cw = cap;
                        cw_count++;
                        cap_n = -1;
                    end
                end
            end
        end
    end

    task automatic send_frame(input msg_t msg, input int extra_at, input int reset_at, input int gap);
        int  waited;
        int  a;
        cw_t cw;
        waited = 0;
        while (!(sys_rst_n && cyc >= next_ready)) begin
            sync    = 1'($urandom_range(0, 1));
            data_in = 8'($urandom);
            step();
            waited++;
            if (waited > 2000) begin
                chk("ready_timeout", 0, 1);
                return;
            end
        end
        for (int g = 0; g < gap; g++) begin
            sync    = 1'b1;
            data_in = 8'($urandom);
            step();
        end
        a = cyc;
        encode(msg, cw);
        for (int j = 0; j < N; j++) exp_data[a+1+j] = cw[j];
        exp_first[a+1] = 1'b1;
        sync    = 1'b0;
        data_in = msg[0];
        step();
        next_ready = a + N;
        for (int j = 1; j < K; j++) begin
            if (j == reset_at) begin
                int p;
                sync      = 1'b1;
                sys_rst_n = 1'b0;
                p = cyc;
                for (int c = p; c < p + N + 2; c++) begin
                    if (exp_data.exists(c)) exp_data.delete(c);
                    if (exp_first.exists(c)) exp_first.delete(c);
                end
                next_ready = 1 << 30;
                repeat (3) step();
                sys_rst_n  = 1'b1;
                next_ready = cyc + 1;
                return;
            end
            sync    = (j == extra_at) ? 1'b0 : 1'b1;
            data_in = msg[j];
            step();
        end
        sync    = 1'b1;
        data_in = 8'($urandom);
    endtask

    task automatic wait_cw(input int target);
        int w;
        w = 0;
        while (cw_count < target && w < 700) begin
            step();
            w++;
        end
        chk("codeword_wait", cw_count >= target, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog cyc=%0d actual=timeout required=finish", cyc);
        $fatal(1);
    end

    initial begin
        msg_t msg;
        int   nz;
        build_tables();
        chk("pin_alpha8", gexp[8], 8'h1D);
        chk("pin_alpha9", gexp[9], 8'h3A);
        chk("pin_alpha12", gexp[12], 8'hCD);
        chk("pin_mul", mul(8'h80, 8'h02), 8'h1D);
        build_gen(2);
        chk("pin_g2_c0", gpoly[0], 8'h02);
        chk("pin_g2_c1", gpoly[1], 8'h03);
        chk("pin_g2_c2", gpoly[2], 8'h01);
        build_gen(NP);
        chk("pin_g16_monic", gpoly[16], 8'h01);
        chk("pin_g0", gpoly[0], gexp[120]);

        repeat (3) step();
        sys_rst_n  = 1'b1;
        next_ready = cyc + 1;

        for (int j = 0; j < K; j++) msg[j] = 8'h00;
        send_frame(msg, -1, -1, 2);
        wait_cw(1);
        nz = 0;
        for (int j = 0; j < N; j++) if (last_cw[j] != 8'h00) nz++;
        chk("zero_codeword_nonzero", nz, 0);

        msg[K-1] = 8'h01;
        send_frame(msg, -1, -1, 1);
        wait_cw(2);
        for (int i = 0; i < NP; i++) chk("impulse_parity", last_cw[K+i], gpoly[NP-1-i]);

        for (int f = 0; f < 20; f++) begin
            for (int j = 0; j < K; j++) msg[j] = 8'($urandom);
            send_frame(msg, -1, -1, 0);
        end
        wait_cw(22);

        for (int j = 0; j < K; j++) msg[j] = 8'($urandom);
        send_frame(msg, 100, -1, 3);
        wait_cw(23);

        for (int j = 0; j < K; j++) msg[j] = 8'($urandom);
        send_frame(msg, -1, 50, 1);
        for (int j = 0; j < K; j++) msg[j] = 8'($urandom);
        send_frame(msg, -1, -1, 0);
        wait_cw(24);

        repeat (20) step();
        chk("codeword_count", cw_count, 24);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
